// File: rtl/ui_pkg.sv
// Shared types, colour constants and arm-direction lookup for the glyph drawer.
package ui_pkg;

  typedef enum logic {
    MODE_X    = 1'b0,
    MODE_PLUS = 1'b1
  } mode_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;

  typedef logic [1:0] arm_t;

  typedef enum logic [1:0] {
    DIR_ZERO = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_e;

  typedef struct packed {
    dir_e dx;
    dir_e dy;
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DRAW = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Direction signs of each arm: X walks the diagonals, + the orthogonals.
  function automatic dir_t arm_dir(arm_t arm, mode_e mode);
    dir_t d;
    d.dx = DIR_ZERO;
    d.dy = DIR_ZERO;
    if (mode == MODE_X) begin
      case (arm)
        2'd0:    begin d.dx = DIR_NEG;  d.dy = DIR_NEG;  end
        2'd1:    begin d.dx = DIR_POS;  d.dy = DIR_NEG;  end
        2'd2:    begin d.dx = DIR_POS;  d.dy = DIR_POS;  end
        default: begin d.dx = DIR_NEG;  d.dy = DIR_POS;  end
      endcase
    end else begin
      case (arm)
        2'd0:    begin d.dx = DIR_ZERO; d.dy = DIR_NEG;  end
        2'd1:    begin d.dx = DIR_POS;  d.dy = DIR_ZERO; end
        2'd2:    begin d.dx = DIR_ZERO; d.dy = DIR_POS;  end
        default: begin d.dx = DIR_NEG;  d.dy = DIR_ZERO; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ui_tick_gen.sv
// Frame tick generator: one-cycle tick every FRAME_DIV enabled cycles.
module ui_tick_gen #(
  parameter int unsigned FRAME_DIV = 833334
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(FRAME_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next count: clear wins, otherwise wrap at FRAME_DIV-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register; tick is registered so it is high in the cycle count=FRAME_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= !clr_i && en_i && (cnt_d == CNT_MAX);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ui_glyph_draw.sv
// Animated X / + glyph plotter: one pixel per frame tick into a VGA write port.
module ui_glyph_draw
  import ui_pkg::*;
#(
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned CX          = 79,
  parameter int unsigned CY          = 63,
  parameter int unsigned ARM_LEN     = 4,
  parameter int unsigned FRAME_DIV   = 833334,
  parameter int unsigned START_DELAY = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic           mode,
  input  logic           clear,
  input  logic [2:0]     color_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     color,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam int unsigned K_W  = $clog2(ARM_LEN + 2);
  localparam int unsigned WD_W = $clog2(START_DELAY + 2);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [2:0]       color_q, color_d;
  logic [WD_W-1:0]  wait_q, wait_d;
  arm_t             arm_q, arm_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_acc_c;
  logic             tick;
  dir_t             dir_c;
  logic [X_W-1:0]   px_c;
  logic [Y_W-1:0]   py_c;

  // A start is only taken while fully idle (the done cycle still counts as busy).
  assign start_acc_c = (state_q == S_IDLE) && !busy_q && start;

  ui_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (start_acc_c),
    .en_i  (busy_q),
    .tick_o(tick)
  );

  // Current pixel: centre offset by k along the active arm (k=0 is the centre).
  always_comb begin
    dir_c = arm_dir(arm_q, mode_q);
    case (dir_c.dx)
      DIR_POS: px_c = X_W'(CX) + X_W'(k_q);
      DIR_NEG: px_c = X_W'(CX) - X_W'(k_q);
      default: px_c = X_W'(CX);
    endcase
    case (dir_c.dy)
      DIR_POS: py_c = Y_W'(CY) + Y_W'(k_q);
      DIR_NEG: py_c = Y_W'(CY) - Y_W'(k_q);
      default: py_c = Y_W'(CY);
    endcase
  end

  // Next-state and output logic; abort overrides everything while busy.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    color_d = color_q;
    wait_d  = wait_q;
    arm_d   = arm_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    plot_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_acc_c) begin
          mode_d  = mode_e'(mode);
          color_d = clear ? BLACK : color_in;
          wait_d  = '0;
          arm_d   = '0;
          k_d     = '0;
          state_d = (START_DELAY == 0) ? S_DRAW : S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) begin
          if ((wait_q + WD_W'(1)) == WD_W'(START_DELAY)) begin
            state_d = S_DRAW;
          end else begin
            wait_d = wait_q + WD_W'(1);
          end
        end
      end
      S_DRAW: begin
        if (tick) begin
          x_d    = px_c;
          y_d    = py_c;
          plot_d = 1'b1;
          if (arm_q == arm_t'(3) && k_q == K_W'(ARM_LEN)) begin
            state_d = S_FIN;
          end else if (k_q == K_W'(ARM_LEN)) begin
            arm_d = arm_q + arm_t'(1);
            k_d   = K_W'(1);
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (abort && busy_q) begin
      state_d = S_IDLE;
      plot_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and registered pixel-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_X;
      color_q <= BLACK;
      wait_q  <= '0;
      arm_q   <= '0;
      k_q     <= '0;
      x_q     <= X_W'(CX);
      y_q     <= Y_W'(CY);
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      wait_q  <= wait_d;
      arm_q   <= arm_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ui_glyph_draw.sv
// Bench for ui_glyph_draw: two instances (long/short glyph) against a timing/geometry model.
module tb_ui_glyph_draw;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_s [2];
  logic       abort_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [2:0] color_i = 3'b000;

  logic [7:0] xo [2];
  logic [6:0] yo [2];
  logic [2:0] co [2];
  logic       po [2];
  logic       bo [2];
  logic       dn [2];

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  int t_start = 0;
  int dcnt [2];
  int dtime [2];

  typedef struct {
    int x;
    int y;
    int col;
    int t;
  } cap_t;
  cap_t cap0[$];
  cap_t cap1[$];

  typedef struct {
    bit         act;
    int         e0;
    bit         m;
    logic [2:0] col;
    logic [7:0] x;
    logic [6:0] y;
    bit         plot;
    bit         busy;
    bit         done;
  } ms_t;
  ms_t ms [2];

  always #5 clk = ~clk;

  ui_glyph_draw #(.ARM_LEN(3), .FRAME_DIV(4), .START_DELAY(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .abort(abort_i),
    .mode(mode_i), .clear(clear_i), .color_in(color_i),
    .x(xo[0]), .y(yo[0]), .color(co[0]), .plot(po[0]), .busy(bo[0]), .done(dn[0])
  );

  ui_glyph_draw #(.ARM_LEN(1), .FRAME_DIV(2), .START_DELAY(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .abort(abort_i),
    .mode(mode_i), .clear(clear_i), .color_in(color_i),
    .x(xo[1]), .y(yo[1]), .color(co[1]), .plot(po[1]), .busy(bo[1]), .done(dn[1])
  );

  function automatic int al(int u); return (u == 0) ? 3 : 1; endfunction
  function automatic int fd(int u); return (u == 0) ? 4 : 2; endfunction
  function automatic int sd(int u); return (u == 0) ? 2 : 0; endfunction

  // Pixel i of the glyph: centre first, then arms 0..3 stepping k=1..ARM_LEN outwards.
  function automatic void pix(int u, int i, bit m, output logic [7:0] px, output logic [6:0] py);
    int arm, k, dx, dy;
    int xs_x[4] = '{-1, 1, 1, -1};
    int ys_x[4] = '{-1, -1, 1, 1};
    int xs_p[4] = '{0, 1, 0, -1};
    int ys_p[4] = '{-1, 0, 1, 0};
    if (i == 0) begin
      k = 0; arm = 0;
    end else begin
      arm = (i - 1) / al(u);
      k   = (i - 1) % al(u) + 1;
    end
    dx = m ? xs_p[arm] : xs_x[arm];
    dy = m ? ys_p[arm] : ys_x[arm];
    px = 8'(79 + dx * k);
    py = 7'(63 + dy * k);
  endfunction

  function automatic ms_t ms_reset();
    ms_t r;
    r.act = 0; r.e0 = 0; r.m = 0; r.col = 3'b000;
    r.x = 8'd79; r.y = 7'd63; r.plot = 0; r.busy = 0; r.done = 0;
    return r;
  endfunction

  // Expected outputs for the cycle following edge n, from the start edge and the timing rules.
  function automatic ms_t ms_step(int u, ms_t s, int n, bit st, bit ab, bit md, bit cl, logic [2:0] ci);
    ms_t r;
    int rel, fs, last;
    r = s;
    r.plot = 0;
    r.done = 0;
    r.busy = 0;
    if (st && !s.busy) begin
      r.act = 1; r.e0 = n; r.m = md; r.col = cl ? 3'b000 : ci;
    end else if (ab && s.busy) begin
      r.act = 0;
    end
    if (r.act) begin
      rel  = n - r.e0;
      fs   = (sd(u) + 1) * fd(u);
      last = fs + 4 * al(u) * fd(u);
      if (rel > last + 1) begin
        r.act = 0;
      end else begin
        r.busy = 1;
        r.done = (rel == last + 1);
        if (rel >= fs && rel <= last && ((rel - fs) % fd(u)) == 0) begin
          r.plot = 1;
          pix(u, (rel - fs) / fd(u), r.m, r.x, r.y);
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  // Model update on each edge; async reset returns it to reset values.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int u = 0; u < 2; u++) ms[u] <= ms_reset();
    end else begin
      for (int u = 0; u < 2; u++)
        ms[u] <= ms_step(u, ms[u], ecnt + 1, start_s[u], abort_i, mode_i, clear_i, color_i);
    end
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model, plus plot/done capture.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d plot", u), int'(po[u]), int'(ms[u].plot));
      chk($sformatf("u%0d busy", u), int'(bo[u]), int'(ms[u].busy));
      chk($sformatf("u%0d done", u), int'(dn[u]), int'(ms[u].done));
      chk($sformatf("u%0d x", u), int'(xo[u]), int'(ms[u].x));
      chk($sformatf("u%0d y", u), int'(yo[u]), int'(ms[u].y));
      chk($sformatf("u%0d color", u), int'(co[u]), int'(ms[u].col));
      if (po[u] === 1'b1) begin
        if (u == 0) cap0.push_back('{int'(xo[0]), int'(yo[0]), int'(co[0]), ecnt});
        else        cap1.push_back('{int'(xo[1]), int'(yo[1]), int'(co[1]), ecnt});
      end
      if (dn[u] === 1'b1) begin
        dcnt[u]++;
        dtime[u] = ecnt;
      end
    end
  end

  task automatic do_start(int u, bit md, bit cl, logic [2:0] c);
    @(posedge clk); #1;
    if (u == 0) cap0.delete(); else cap1.delete();
    mode_i = md; clear_i = cl; color_i = c;
    start_s[u] = 1'b1;
    t_start = ecnt + 1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
  endtask

  task automatic wait_done(int u, int bound);
    int d0;
    bit seen;
    d0 = dcnt[u];
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (dcnt[u] != d0) seen = 1;
    end
    if (!seen) chk($sformatf("u%0d done timeout", u), 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_caps(int n, int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (cap0.size() >= n) seen = 1;
    end
    if (!seen) chk("plot count timeout", cap0.size(), n);
  endtask

  // Literal check of a captured sequence, its colour and first/last plot timing.
  task automatic check_seq(int u, string nm, int n, int xs[13], int ys[13], int col, int tf, int tl);
    cap_t c[$];
    c = (u == 0) ? cap0 : cap1;
    chk({nm, " count"}, c.size(), n);
    for (int i = 0; i < n && i < c.size(); i++) begin
      chk($sformatf("%s x[%0d]", nm, i), c[i].x, xs[i]);
      chk($sformatf("%s y[%0d]", nm, i), c[i].y, ys[i]);
      chk($sformatf("%s col[%0d]", nm, i), c[i].col, col);
    end
    if (c.size() == n) begin
      chk({nm, " first t"}, c[0].t - t_start, tf);
      chk({nm, " last t"}, c[n-1].t - t_start, tl);
    end
  endtask

  initial begin
    int xs1[13] = '{79, 78, 77, 76, 80, 81, 82, 80, 81, 82, 78, 77, 76};
    int ys1[13] = '{63, 62, 61, 60, 62, 61, 60, 64, 65, 66, 64, 65, 66};
    int xs2[13] = '{79, 79, 79, 79, 80, 81, 82, 79, 79, 79, 78, 77, 76};
    int ys2[13] = '{63, 62, 61, 60, 63, 63, 63, 64, 65, 66, 63, 63, 63};
    int xs6[13] = '{79, 78, 80, 80, 78, 0, 0, 0, 0, 0, 0, 0, 0};
    int ys6[13] = '{63, 62, 62, 64, 64, 0, 0, 0, 0, 0, 0, 0, 0};
    int d0;

    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    dcnt[0] = 0; dcnt[1] = 0;
    dtime[0] = 0; dtime[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset x", int'(xo[0]), 79);
    chk("reset y", int'(yo[0]), 63);
    chk("reset busy", int'(bo[0]), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: X glyph in red
    do_start(0, 1'b0, 1'b0, 3'b100);
    wait_done(0, 120);
    check_seq(0, "t1", 13, xs1, ys1, 4, 12, 60);
    chk("t1 done t", dtime[0] - t_start, 61);
    chk("t1 busy after", int'(bo[0]), 0);

    // 2: + glyph, erase
    do_start(0, 1'b1, 1'b1, 3'b111);
    wait_done(0, 120);
    check_seq(0, "t2", 13, xs2, ys2, 0, 12, 60);

    // 3: restart and input changes mid-draw are ignored
    d0 = dcnt[0];
    do_start(0, 1'b0, 1'b0, 3'b100);
    wait_caps(3, 60);
    @(posedge clk); #1;
    start_s[0] = 1'b1; mode_i = 1'b1; clear_i = 1'b1; color_i = 3'b011;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(0, 120);
    repeat (20) @(negedge clk);
    check_seq(0, "t3", 13, xs1, ys1, 4, 12, 60);
    chk("t3 done count", dcnt[0] - d0, 1);

    // 4: abort after the fifth plot, then a clean restart
    d0 = dcnt[0];
    do_start(0, 1'b0, 1'b0, 3'b100);
    wait_caps(5, 60);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("t4 busy after abort", int'(bo[0]), 0);
    repeat (70) @(negedge clk);
    chk("t4 plots after abort", cap0.size(), 5);
    chk("t4 no done", dcnt[0] - d0, 0);
    do_start(0, 1'b0, 1'b0, 3'b100);
    wait_done(0, 120);
    check_seq(0, "t4 restart", 13, xs1, ys1, 4, 12, 60);

    // 5: asynchronous reset mid-draw
    do_start(0, 1'b1, 1'b0, 3'b010);
    wait_caps(3, 60);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("t5 x", int'(xo[0]), 79);
    chk("t5 y", int'(yo[0]), 63);
    chk("t5 color", int'(co[0]), 0);
    chk("t5 plot", int'(po[0]), 0);
    chk("t5 busy", int'(bo[0]), 0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    do_start(0, 1'b0, 1'b0, 3'b100);
    wait_done(0, 120);
    check_seq(0, "t5 restart", 13, xs1, ys1, 4, 12, 60);

    // 6: short glyph, no start delay, fastest tick
    do_start(1, 1'b0, 1'b0, 3'b010);
    wait_done(1, 40);
    check_seq(1, "t6", 5, xs6, ys6, 2, 2, 10);
    chk("t6 done t", dtime[1] - t_start, 11);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ui_glyph_draw.md
Name: ui_glyph_draw

Overview:
Parametrised successor to the fixed "wrong" X drawer. Plots a four-arm glyph centred on (CX,CY) one pixel per frame tick, giving an animated reveal. The glyph is an X (diagonals) or a + (orthogonals), selected per draw. Sits between the game FSM (start/abort/done handshake) and the VGA adapter pixel-write port (x, y, color, plot).

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
CX, 79, glyph centre x
CY, 63, glyph centre y
ARM_LEN, 4, pixels per arm excluding centre (>=1)
FRAME_DIV, 833334, clk cycles per tick (>=2)
START_DELAY, 4, ticks of idle before the first pixel (>=0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
abort  in  1  synchronous cancel; returns to IDLE, no done
mode  in  1  0 = X, 1 = +; latched on accepted start
clear  in  1  1 = draw black (erase); latched on accepted start
color_in  in  3  RGB colour; latched on accepted start
x  out  X_W  pixel x
y  out  Y_W  pixel y
color  out  3  pixel colour (000 when clear latched)
plot  out  1  pixel write strobe, one cycle per pixel
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (async, reset_n=0): state IDLE; x=CX, y=CY, color=000, plot=0, busy=0, done=0; all counters 0.
- States: IDLE -> WAIT -> DRAW -> FIN -> IDLE.
- IDLE: start=1 at edge E0 latches mode/clear/color_in, clears the tick counter, sets busy; goes to WAIT, or straight to DRAW if START_DELAY=0.
- Tick generator: counts 0..FRAME_DIV-1 while busy; tick high in the cycle with count=FRAME_DIV-1. The n-th tick is sampled at edge E0+n*FRAME_DIV.
- WAIT: counts START_DELAY ticks, then enters DRAW.
- DRAW: each tick registers one pixel, so plot=1 for exactly the following cycle. Pixel count P = 1+4*ARM_LEN.
  - First tick in DRAW plots the centre (CX,CY).
  - Then arms 0..3, k = 1..ARM_LEN within each arm.
  - X mode direction (dx,dy): arm0 (-,-), arm1 (+,-), arm2 (+,+), arm3 (-,+).
  - + mode direction: arm0 (0,-), arm1 (+,0), arm2 (0,+), arm3 (-,0).
  - Pixel = (CX+dx*k, CY+dy*k), arithmetic modulo 2^X_W / 2^Y_W, no clipping.
- The first plot is high in the cycle after edge E0+(START_DELAY+1)*FRAME_DIV. Plots are spaced FRAME_DIV cycles apart.
- FIN: in the cycle after the last plot, done=1 for one cycle and busy stays 1. busy=0 from the following cycle, in IDLE.
- x/y hold their last value when plot=0. color is constant during a draw.
- Simultaneous events and mid-operation changes:
  - start while busy: ignored.
  - mode/clear/color_in changes while busy: no effect.
  - abort while busy: IDLE at the next edge; plot, busy and done are 0 from the next cycle; no done pulse. abort in IDLE: no effect.
  - start and abort in the same cycle in IDLE: start wins. Both while busy: abort wins.
  - reset_n low mid-draw: immediate return to reset values.

Decomposition:
- Package ui_pkg: mode encodings (MODE_X, MODE_PLUS), colour constants (BLACK 000, GREEN 010, RED 100), arm index type, and the direction-sign lookup function (arm, mode) -> (dx,dy).
- Sub-module ui_tick_gen (parametrised FRAME_DIV, synchronous clear and enable, tick output). It replaces the separate rate divider / frame counter pair.

Test Plan:
1. ARM_LEN=3, FRAME_DIV=4, START_DELAY=2, mode=0, color_in=100, start at E0:
   - 13 plots with color 100, in order (79,63),(78,62),(77,61),(76,60),(80,62),(81,61),(82,60),(80,64),(81,65),(82,66),(78,64),(77,65),(76,66).
   - First plot high the cycle after E0+12; plots spaced 4 cycles; last plot after E0+60.
   - done pulses the next cycle; busy low the cycle after that.
2. Same parameters, mode=1, clear=1 -> color 000 on every plot; sequence (79,63),(79,62),(79,61),(79,60),(80,63),(81,63),(82,63),(79,64),(79,65),(79,66),(78,63),(77,63),(76,63).
3. During test 1, pulse start again and flip mode/color_in mid-draw -> sequence and colour unchanged; exactly one done.
4. abort after the 5th plot -> no further plot, no done, busy=0 next cycle. A new start then reproduces the full 13-pixel sequence with correct timing.
5. reset_n low asynchronously mid-draw (between edges) -> outputs go to reset values immediately. After release, IDLE; start works normally.
6. START_DELAY=0, ARM_LEN=1, FRAME_DIV=2 -> 5 plots: (79,63),(78,62),(80,62),(80,64),(78,64). First plot the cycle after E0+2; done after the 5th plot.
